mcs4_clockgen: RTL
==================

Name: mcs4_clockgen

Overview:
Generates the MCS-4 two-phase non-overlapping clocks (clk1_pad, clk2_pad) and power-on clear (poc_pad) from sysclk. Sits directly upstream of every i4001/i4002/i4004 instance and feeds their clk1_pad/clk2_pad/poc_pad inputs. Provides run/stop and single-step control for the debug front panel.

Parameters:
CLK_PERIOD, 68, sysclk cycles per MCS-4 clock period (735 kHz at 50 MHz sysclk)
CLK1_HIGH, 20, sysclk cycles clk1 is high
CLK_GAP, 14, sysclk cycles from clk1 fall to clk2 rise
CLK2_HIGH, 20, sysclk cycles clk2 is high; the gap from clk2 fall to the next clk1 rise is the remainder
POC_PERIODS, 16, full clock periods poc_pad is held after reset or poc_req

Ports:
sysclk  input  1  system clock; all logic on its rising edge
sysreset_n  input  1  synchronous active-low reset
run  input  1  level: 1 = free-run clocks, 0 = stop at the next period boundary
step  input  1  one-sysclk pulse; while STOPPED, runs exactly one period
poc_req  input  1  one-sysclk pulse; re-arms power-on clear
clk1_pad  output  1  phase-1 clock
clk2_pad  output  1  phase-2 clock
poc_pad  output  1  power-on clear, active high
period_end  output  1  one-sysclk strobe in the last cycle of each generated period
running  output  1  1 while not STOPPED

Behaviour:
- One clock (sysclk). Reset is synchronous, active-low (sysreset_n), sampled on the rising edge of sysclk.
- Reset values: clk1_pad=0, clk2_pad=0, period_end=0, running=0, poc_pad=1, cnt=0, poc_cnt=0, state=STOPPED.
- Elaboration check: every timing parameter >=1 and CLK1_HIGH+CLK_GAP+CLK2_HIGH < CLK_PERIOD, otherwise an elaboration error. This guarantees a nonzero clk2-to-clk1 gap.
- cnt is ceil(log2(CLK_PERIOD)) bits, counts 0..CLK_PERIOD-1, and wraps to 0. It advances only in RUNNING or STEP.
- Outputs are flops (glitch-free), each one sysclk behind the cnt decode:
  - clk1_pad(t+1) = active & (cnt < CLK1_HIGH)
  - clk2_pad(t+1) = active & (cnt >= CLK1_HIGH+CLK_GAP) & (cnt < CLK1_HIGH+CLK_GAP+CLK2_HIGH)
  - period_end(t+1) = active & (cnt == CLK_PERIOD-1)
  - active = state in {RUNNING, STEP}
- clk1_pad and clk2_pad are never high in the same cycle.
- States:
  - STOPPED: cnt held at 0, both clocks low.
    - run=1 -> RUNNING.
    - Otherwise step=1 -> STEP.
    - run has priority over step.
  - RUNNING: cnt advances.
    - At cnt==CLK_PERIOD-1 with run=0 -> STOPPED; cnt wraps to 0.
    - run dropping mid-period never truncates a pulse; the period always completes.
  - STEP: cnt advances.
    - At cnt==CLK_PERIOD-1 -> RUNNING if run=1, else STOPPED.
    - step pulses during STEP or RUNNING are ignored (not queued).
- running = (state != STOPPED), registered with the state.
- POC:
  - poc_cnt counts completed periods, incrementing when period_end is asserted, and saturates at POC_PERIODS.
  - poc_pad = (poc_cnt < POC_PERIODS), registered. It deasserts in the cycle after the POC_PERIODS-th period_end, i.e. aligned to a period boundary.
  - poc_req clears poc_cnt to 0 next cycle, and poc_pad goes 1 next cycle. This applies in any state; when STOPPED, poc_pad stays 1 until enough periods are run.
  - If poc_req coincides with period_end, the clear wins and the increment is dropped.
- Reset mid-period: clocks drop to 0 immediately on the next edge, with no partial pulse completion; poc_pad returns to 1.

Test Plan:
1. Reset, then run=1 held (defaults) -> clk1_pad is high for 20 cycles, low 14, clk2_pad high 20, both low 14, repeating with period 68. The first clk1 rise is 2 sysclk after the first cycle with sysreset_n=1 and run=1. clk1&clk2 is never 1.
2. Free run from reset -> poc_pad=1 through 16 period_end strobes, 0 in the cycle after the 16th. period_end is exactly one cycle wide every 68 cycles.
3. Drop run at cnt=5 (mid clk1) -> the current period completes in full (clk1 20 wide, clk2 20 wide). running goes 0 after period_end; clocks stay low.
4. STOPPED, step pulse -> exactly one clk1 pulse and one clk2 pulse, one period_end, then STOPPED. A second step pulse issued mid-period produces no extra period.
5. Running with poc_pad=0, poc_req pulse -> poc_pad=1 next cycle, then 0 again after 16 further period_end strobes. A poc_req coincident with period_end -> the count restarts from 0.
6. Assert sysreset_n=0 while clk2_pad=1 -> next edge: clk2_pad=0, clk1_pad=0, poc_pad=1, running=0. A parameter set with CLK1_HIGH+CLK_GAP+CLK2_HIGH=68 -> elaboration fails.

Source files
------------

// File: rtl/mcs4_clk_if.sv
// MCS-4 clock generator bus: front-panel controls in, two-phase clocks and
// power-on clear out. The generator uses 'master'; consumers use 'slave'.
interface mcs4_clk_if;
   logic run;
   logic step;
   logic poc_req;
   logic clk1_pad;
   logic clk2_pad;
   logic poc_pad;
   logic period_end;
   logic running;

   modport master (
      input  run, step, poc_req,
      output clk1_pad, clk2_pad, poc_pad, period_end, running
   );

   modport slave (
      output run, step, poc_req,
      input  clk1_pad, clk2_pad, poc_pad, period_end, running
   );
endinterface

// File: rtl/mcs4_clockgen.sv
// MCS-4 two-phase non-overlapping clock and power-on-clear generator.
// A period counter is decoded into registered clk1/clk2/period_end so the
// pads are glitch-free; run/step control only ever stops on a period
// boundary so no pulse is ever truncated.
module mcs4_clockgen #(
   parameter int CLK_PERIOD  = 68,
   parameter int CLK1_HIGH   = 20,
   parameter int CLK_GAP     = 14,
   parameter int CLK2_HIGH   = 20,
   parameter int POC_PERIODS = 16
) (
   input  logic       sysclk,
   input  logic       sysreset_n,
   mcs4_clk_if.master bus
);

   // Reject timing sets that would leave no clk2-to-clk1 gap.
   if (CLK_PERIOD < 1 || CLK1_HIGH < 1 || CLK_GAP < 1 || CLK2_HIGH < 1 ||
       POC_PERIODS < 1 || (CLK1_HIGH + CLK_GAP + CLK2_HIGH) >= CLK_PERIOD) begin : g_param_check
      $error("mcs4_clockgen: invalid clock timing parameters");
   end

   localparam int CNT_W = (CLK_PERIOD > 2) ? $clog2(CLK_PERIOD) : 1;
   localparam int POC_W = $clog2(POC_PERIODS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_PERIOD - 1);
   localparam logic [CNT_W-1:0] CLK1_END   = CNT_W'(CLK1_HIGH);
   localparam logic [CNT_W-1:0] CLK2_START = CNT_W'(CLK1_HIGH + CLK_GAP);
   localparam logic [CNT_W-1:0] CLK2_END   = CNT_W'(CLK1_HIGH + CLK_GAP + CLK2_HIGH);
   localparam logic [POC_W-1:0] POC_DONE   = POC_W'(POC_PERIODS);

   localparam logic [1:0] ST_STOPPED = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_STEP    = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [POC_W-1:0] poc_cnt_reg, poc_cnt_next;
   logic             clk1_reg, clk1_next;
   logic             clk2_reg, clk2_next;
   logic             period_end_reg, period_end_next;
   logic             poc_pad_reg, poc_pad_next;
   logic             running_reg, running_next;
   logic             active;
   logic             cnt_at_last;

   // Run/step sequencing and period counter; stops only at the period end.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      cnt_at_last = (cnt_reg == CNT_LAST);
      case (state_reg)
         ST_STOPPED: begin
            cnt_next = '0;
            if (bus.run) begin
               state_next = ST_RUNNING;
            end else if (bus.step) begin
               state_next = ST_STEP;
            end
         end
         ST_RUNNING: begin
            if (cnt_at_last) begin
               cnt_next = '0;
               if (!bus.run) begin
                  state_next = ST_STOPPED;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_STEP: begin
            if (cnt_at_last) begin
               cnt_next   = '0;
               state_next = bus.run ? ST_RUNNING : ST_STOPPED;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_STOPPED;
            cnt_next   = '0;
         end
      endcase
      running_next = (state_next != ST_STOPPED);
   end

   // Phase decode of the current count; registered one sysclk later.
   always_comb begin
      active          = (state_reg == ST_RUNNING) || (state_reg == ST_STEP);
      clk1_next       = active && (cnt_reg < CLK1_END);
      clk2_next       = active && (cnt_reg >= CLK2_START) && (cnt_reg < CLK2_END);
      period_end_next = active && (cnt_reg == CNT_LAST);
   end

   // Power-on clear: count completed periods, a re-arm request beats an increment.
   always_comb begin
      poc_cnt_next = poc_cnt_reg;
      if (bus.poc_req) begin
         poc_cnt_next = '0;
      end else if (period_end_reg && (poc_cnt_reg != POC_DONE)) begin
         poc_cnt_next = poc_cnt_reg + 1'b1;
      end
      poc_pad_next = (poc_cnt_next < POC_DONE);
   end

   // State, counters and output flops; reset drops the clocks immediately.
   always_ff @(posedge sysclk) begin
      if (!sysreset_n) begin
         state_reg      <= ST_STOPPED;
         cnt_reg        <= '0;
         poc_cnt_reg    <= '0;
         clk1_reg       <= 1'b0;
         clk2_reg       <= 1'b0;
         period_end_reg <= 1'b0;
         poc_pad_reg    <= 1'b1;
         running_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         poc_cnt_reg    <= poc_cnt_next;
         clk1_reg       <= clk1_next;
         clk2_reg       <= clk2_next;
         period_end_reg <= period_end_next;
         poc_pad_reg    <= poc_pad_next;
         running_reg    <= running_next;
      end
   end

   assign bus.clk1_pad   = clk1_reg;
   assign bus.clk2_pad   = clk2_reg;
   assign bus.period_end = period_end_reg;
   assign bus.poc_pad    = poc_pad_reg;
   assign bus.running    = running_reg;

endmodule
